// File: rtl/memc_dma_port_if.sv
// DMA request/return and single-port SRAM bus bundle for memc_dma_port.
// slave = memory-controller view, master = DMA + SRAM environment view.
interface memc_dma_port_if #(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 32
);
    logic                  dma__memc__write_valid;
    logic [ADDR_WIDTH-1:0] dma__memc__write_address;
    logic [DATA_WIDTH-1:0] dma__memc__write_data;
    logic                  memc__dma__write_ready;

    logic                  dma__memc__read_valid;
    logic [ADDR_WIDTH-1:0] dma__memc__read_address;
    logic                  dma__memc__read_pause;
    logic                  memc__dma__read_ready;
    logic [DATA_WIDTH-1:0] memc__dma__read_data;
    logic                  memc__dma__read_data_valid;

    logic                  memc__sram__cs;
    logic                  memc__sram__we;
    logic [ADDR_WIDTH-1:0] memc__sram__address;
    logic [DATA_WIDTH-1:0] memc__sram__write_data;
    logic [DATA_WIDTH-1:0] sram__memc__read_data;

    modport slave (
        input  dma__memc__write_valid, dma__memc__write_address, dma__memc__write_data,
        input  dma__memc__read_valid, dma__memc__read_address, dma__memc__read_pause,
        input  sram__memc__read_data,
        output memc__dma__write_ready, memc__dma__read_ready,
        output memc__dma__read_data, memc__dma__read_data_valid,
        output memc__sram__cs, memc__sram__we, memc__sram__address, memc__sram__write_data
    );

    modport master (
        output dma__memc__write_valid, dma__memc__write_address, dma__memc__write_data,
        output dma__memc__read_valid, dma__memc__read_address, dma__memc__read_pause,
        output sram__memc__read_data,
        input  memc__dma__write_ready, memc__dma__read_ready,
        input  memc__dma__read_data, memc__dma__read_data_valid,
        input  memc__sram__cs, memc__sram__we, memc__sram__address, memc__sram__write_data
    );
endinterface

// File: rtl/memc_dma_port.sv
// DMA-to-single-port-SRAM controller: write/read arbitration, credited in-order read return FIFO.
// Optional access counters enabled by defining MEMC_DMA_PORT_ACCESS_CNT_EN.
module memc_dma_port #(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 32,
    parameter int RDQ_DEPTH  = 4    // power of 2, >= 2
) (
    input  logic clk,
    input  logic reset_poweron_n,
`ifdef MEMC_DMA_PORT_ACCESS_CNT_EN
    output logic [15:0] memc__stat__write_count,
    output logic [15:0] memc__stat__read_count,
`endif
    memc_dma_port_if.slave bus
);
    localparam int PTR_W = $clog2(RDQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic                  wr_grant;
    logic                  rd_grant;
    logic                  prio_rd;      // 1: read wins the next contended cycle
    logic                  read_ok;
    logic [CNT_W:0]        credit_used;

    // vld_pipe[0]: SRAM read strobe on the bus, vld_pipe[1]: SRAM read data on the bus
    logic [1:0]            vld_pipe;
    logic                  push;
    logic                  pop;

    logic [DATA_WIDTH-1:0] rdq [RDQ_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      occ;

    // Reads already issued to the SRAM hold a FIFO slot until they land.
    assign credit_used = (CNT_W+1)'(occ) + (CNT_W+1)'(vld_pipe[0]) + (CNT_W+1)'(vld_pipe[1]);
    assign read_ok     = credit_used < (CNT_W+1)'(RDQ_DEPTH);

    always_comb begin
        wr_grant = 1'b0;
        rd_grant = 1'b0;
        if (reset_poweron_n) begin
            if (bus.dma__memc__write_valid &&
                !(bus.dma__memc__read_valid && read_ok && prio_rd))
                wr_grant = 1'b1;
            else if (bus.dma__memc__read_valid && read_ok)
                rd_grant = 1'b1;
        end
    end

    assign bus.memc__dma__write_ready = wr_grant;
    assign bus.memc__dma__read_ready  = rd_grant;

    always_ff @(posedge clk or negedge reset_poweron_n) begin
        if (!reset_poweron_n) begin
            prio_rd <= 1'b0;
        end else if (wr_grant) begin
            prio_rd <= 1'b1;
        end else if (rd_grant) begin
            prio_rd <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_poweron_n) begin
        if (!reset_poweron_n) begin
            bus.memc__sram__cs         <= 1'b0;
            bus.memc__sram__we         <= 1'b0;
            bus.memc__sram__address    <= '0;
            bus.memc__sram__write_data <= '0;
            vld_pipe                   <= '0;
        end else begin
            bus.memc__sram__cs <= wr_grant | rd_grant;
            bus.memc__sram__we <= wr_grant;
            if (wr_grant) begin
                bus.memc__sram__address    <= bus.dma__memc__write_address;
                bus.memc__sram__write_data <= bus.dma__memc__write_data;
            end else if (rd_grant) begin
                bus.memc__sram__address    <= bus.dma__memc__read_address;
            end
            vld_pipe <= {vld_pipe[0], rd_grant};
        end
    end

    assign push = vld_pipe[1];
    assign pop  = (occ != '0) && !bus.dma__memc__read_pause;

    always_ff @(posedge clk) begin
        if (push)
            rdq[wr_ptr] <= bus.sram__memc__read_data;
    end

    always_ff @(posedge clk or negedge reset_poweron_n) begin
        if (!reset_poweron_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   occ <= occ + CNT_W'(1);
                2'b01:   occ <= occ - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Head is zeroed whenever it is not being delivered, so reset/empty show 0.
    assign bus.memc__dma__read_data_valid = pop;
    assign bus.memc__dma__read_data       = pop ? rdq[rd_ptr] : '0;

`ifdef MEMC_DMA_PORT_ACCESS_CNT_EN
    logic [15:0] wr_cnt;
    logic [15:0] rd_cnt;

    always_ff @(posedge clk or negedge reset_poweron_n) begin
        if (!reset_poweron_n) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (wr_grant && wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
            if (rd_grant && rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
        end
    end

    assign memc__stat__write_count = wr_cnt;
    assign memc__stat__read_count  = rd_cnt;
`endif
endmodule

// File: tb/tb_memc_dma_port.sv
// Self-checking bench for memc_dma_port: ready table, scoreboarded read returns, corner sequences.
module tb_memc_dma_port;
  localparam int AW    = 24;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  memc_dma_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef MEMC_DMA_PORT_ACCESS_CNT_EN
  logic [15:0] wcnt, rcnt;
`endif

  memc_dma_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RDQ_DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset_poweron_n(rst_n),
`ifdef MEMC_DMA_PORT_ACCESS_CNT_EN
    .memc__stat__write_count(wcnt),
    .memc__stat__read_count(rcnt),
`endif
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: registered read, data valid one cycle after the strobe
  logic [DW-1:0] sram [256];
  always @(posedge clk) begin
    if (bus.memc__sram__cs && bus.memc__sram__we)
      sram[bus.memc__sram__address[7:0]] <= bus.memc__sram__write_data;
    bus.sram__memc__read_data <= (bus.memc__sram__cs && !bus.memc__sram__we) ?
                                 sram[bus.memc__sram__address[7:0]] : 32'h0BAD_0BAD;
  end

  // reference memory + scoreboard
  logic [DW-1:0] shadow [256];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got[$];
  int            dv_cyc[$];
  logic          grant_log[$];  // 0 = write, 1 = read
  int            wr_acc = 0, rd_acc = 0, last_acc_cyc = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.dma__memc__write_valid && bus.memc__dma__write_ready) begin
        shadow[bus.dma__memc__write_address[7:0]] = bus.dma__memc__write_data;
        wr_acc++;
        grant_log.push_back(1'b0);
      end
      if (bus.dma__memc__read_valid && bus.memc__dma__read_ready) begin
        exp_q.push_back(shadow[bus.dma__memc__read_address[7:0]]);
        rd_acc++;
        last_acc_cyc = cyc;
        grant_log.push_back(1'b1);
      end
      if (bus.dma__memc__write_valid && bus.dma__memc__read_valid) begin
        checks++;
        if (bus.memc__dma__write_ready && bus.memc__dma__read_ready) begin
          errors++;
          $display("FAIL both_ready: write_ready=1 read_ready=1 at cycle %0d, required at most one", cyc);
        end
      end
      if (bus.memc__dma__read_data_valid) begin
        got.push_back(bus.memc__dma__read_data);
        dv_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_data: got 0x%0h at cycle %0d, required no data", bus.memc__dma__read_data, cyc);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          if (bus.memc__dma__read_data !== e) begin
            errors++;
            $display("FAIL read_data: got 0x%0h required 0x%0h", bus.memc__dma__read_data, e);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic rv, input logic [AW-1:0] ra, input logic p);
    @(posedge clk); #1;
    bus.dma__memc__write_valid   = wv;
    bus.dma__memc__write_address = wa;
    bus.dma__memc__write_data    = wd;
    bus.dma__memc__read_valid    = rv;
    bus.dma__memc__read_address  = ra;
    bus.dma__memc__read_pause    = p;
  endtask

  task automatic idle(input int n, input logic p);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, '0, p);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    bus.dma__memc__write_valid = 1'b0;
    bus.dma__memc__read_valid  = 1'b0;
    bus.dma__memc__read_pause  = 1'b0;
    exp_q.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive(1'b1, a, d, 1'b0, '0, 1'b0);
    @(negedge clk);
    chk("write_only_ready", {63'd0, bus.memc__dma__write_ready}, 64'd1);
  endtask

  typedef struct packed { logic wv; logic rv; logic exp_wr; logic exp_rr; } vec_t;
  vec_t tbl [11];

  initial begin
    int base, k, n;
    logic p;

    for (int i = 0; i < 256; i++) begin sram[i] = '0; shadow[i] = '0; end
    bus.dma__memc__write_valid   = 1'b1;
    bus.dma__memc__write_address = '0;
    bus.dma__memc__write_data    = '0;
    bus.dma__memc__read_valid    = 1'b1;
    bus.dma__memc__read_address  = '0;
    bus.dma__memc__read_pause    = 1'b0;

    // reset state, valids asserted while in reset
    #12;
    chk("rst_write_ready", {63'd0, bus.memc__dma__write_ready}, 64'd0);
    chk("rst_read_ready",  {63'd0, bus.memc__dma__read_ready}, 64'd0);
    chk("rst_cs",          {63'd0, bus.memc__sram__cs}, 64'd0);
    chk("rst_data_valid",  {63'd0, bus.memc__dma__read_data_valid}, 64'd0);
    do_reset();

    // arbitration/credit table, pause held so the FIFO fills
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0};
    got.delete(); dv_cyc.delete();
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].wv, AW'(8'h40 + i), 32'hA500_0000 + i, tbl[i].rv, AW'(8'h40 + i / 2), 1'b1);
      @(negedge clk);
      chk($sformatf("tbl%0d_write_ready", i), {63'd0, bus.memc__dma__write_ready}, {63'd0, tbl[i].exp_wr});
      chk($sformatf("tbl%0d_read_ready", i),  {63'd0, bus.memc__dma__read_ready},  {63'd0, tbl[i].exp_rr});
    end
    chk("tbl_paused_no_data", 64'(got.size()), 64'd0);
    idle(8, 1'b0);
    chk("tbl_drain_beats", 64'(got.size()), 64'd4);
    if (dv_cyc.size() == 4) chk("tbl_drain_consecutive", 64'(dv_cyc[3] - dv_cyc[0]), 64'd3);

    // write then read same address: 3-cycle latency, new data
    do_reset();
    do_write(AW'(8'h10), 32'hDEADBEEF);
    drive(1'b0, '0, '0, 1'b1, AW'(8'h10), 1'b0);
    @(negedge clk);
    chk("raw_read_ready", {63'd0, bus.memc__dma__read_ready}, 64'd1);
    base = cyc;
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
    n = 0;
    while (!bus.memc__dma__read_data_valid && n < 10) begin @(negedge clk); n++; end
    if (n >= 10) begin
      errors++; checks++;
      $display("FAIL raw_timeout: no read_data_valid within 10 cycles, required one");
    end else begin
      chk("raw_latency", 64'(cyc - base), 64'd3);
      chk("raw_data", {32'd0, bus.memc__dma__read_data}, {32'd0, 32'hDEADBEEF});
    end
    idle(3, 1'b0);

    // both valid 8 cycles: W,R,W,R...
    do_reset();
    grant_log.delete();
    base = wr_acc; k = rd_acc;
    for (int i = 0; i < 8; i++)
      drive(1'b1, AW'(8'h20 + i), 32'h5500_0000 + i, 1'b1, AW'(8'h20), 1'b0);
    @(negedge clk);
    idle(6, 1'b0);
    chk("alt_writes", 64'(wr_acc - base), 64'd4);
    chk("alt_reads",  64'(rd_acc - k), 64'd4);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      chk($sformatf("alt_grant%0d", i), {63'd0, grant_log[i]}, 64'(i % 2));

    // paused credit exhaustion, then drain and resume
    do_reset();
    for (int i = 0; i < 4; i++) do_write(AW'(8'h80 + i), 32'hC0DE_0000 + i);
    got.delete(); dv_cyc.delete();
    base = rd_acc;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, '0, '0, 1'b1, AW'(8'h80 + i), 1'b1);
      @(negedge clk);
      chk($sformatf("pause_rd%0d_ready", i), {63'd0, bus.memc__dma__read_ready}, (i < 4) ? 64'd1 : 64'd0);
    end
    chk("pause_accepted", 64'(rd_acc - base), 64'd4);
    idle(8, 1'b0);
    chk("pause_beats", 64'(got.size()), 64'd4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk($sformatf("pause_beat%0d", i), {32'd0, got[i]}, {32'd0, 32'hC0DE_0000 + i});
    if (dv_cyc.size() == 4) chk("pause_consecutive", 64'(dv_cyc[3] - dv_cyc[0]), 64'd3);
    drive(1'b0, '0, '0, 1'b1, AW'(8'h81), 1'b0);
    @(negedge clk);
    chk("pause_resume_ready", {63'd0, bus.memc__dma__read_ready}, 64'd1);
    idle(6, 1'b0);

    // pause toggling every cycle, reads of addr*3
    do_reset();
    for (int i = 0; i < 8; i++) do_write(AW'(i), 32'(i * 3));
    got.delete();
    k = 0; n = 0; p = 1'b0;
    while (n < 80 && !(k == 8 && got.size() == 8)) begin
      drive(1'b0, '0, '0, k < 8, AW'(k), p);
      @(negedge clk);
      if (k < 8 && bus.memc__dma__read_ready) k++;
      p = ~p; n++;
    end
    idle(4, 1'b0);
    chk("toggle_beats", 64'(got.size()), 64'd8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk($sformatf("toggle_beat%0d", i), {32'd0, got[i]}, 64'(i * 3));

    // reset with 2 reads in flight and 2 in the FIFO
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b0, '0, '0, 1'b1, AW'(8'h80 + i), 1'b1);
    @(posedge clk); #2;
    bus.dma__memc__write_valid = 1'b1;
    bus.dma__memc__read_valid  = 1'b1;
    bus.dma__memc__read_pause  = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_cs",         {63'd0, bus.memc__sram__cs}, 64'd0);
    chk("mid_rst_we",         {63'd0, bus.memc__sram__we}, 64'd0);
    chk("mid_rst_addr",       64'(bus.memc__sram__address), 64'd0);
    chk("mid_rst_wdata",      64'(bus.memc__sram__write_data), 64'd0);
    chk("mid_rst_rdata",      64'(bus.memc__dma__read_data), 64'd0);
    chk("mid_rst_data_valid", {63'd0, bus.memc__dma__read_data_valid}, 64'd0);
    chk("mid_rst_wr_ready",   {63'd0, bus.memc__dma__write_ready}, 64'd0);
    chk("mid_rst_rd_ready",   {63'd0, bus.memc__dma__read_ready}, 64'd0);
    bus.dma__memc__write_valid = 1'b0;
    bus.dma__memc__read_valid  = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    got.delete();
    idle(10, 1'b0);
    chk("post_rst_stale", 64'(got.size()), 64'd0);

`ifdef MEMC_DMA_PORT_ACCESS_CNT_EN
    do_reset();
    chk("cnt_rst_w", 64'(wcnt), 64'd0);
    for (int i = 0; i < 5; i++) do_write(AW'(8'hA0 + i), 32'(i));
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, '0, 1'b1, AW'(8'hA0 + i), 1'b0);
      idle(1, 1'b0);
    end
    idle(5, 1'b0);
    chk("cnt_w5", 64'(wcnt), 64'd5);
    chk("cnt_r3", 64'(rcnt), 64'd3);
    for (int i = 0; i < 70000; i++) drive(1'b1, AW'(8'hC0), 32'(i), 1'b0, '0, 1'b0);
    idle(2, 1'b0);
    chk("cnt_sat", 64'(wcnt), 64'hFFFF);
`endif

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
